mmio_periph: RTL and testbench
==============================

# mmio_periph

Memory-mapped peripheral responder on the core's data memory port (`memory__*` signals), placed beside the word memory in the Tiny Tapeout top level. It decodes a 32-byte address window and serves loads and stores to a GPIO output register, a synchronised GPIO input, a 32-bit cycle timer and a transmit-only UART. The top level selects `memory__read_data` from this block when `hit` is high and from the word memory otherwise.

## Interface
- `BASE`, `32'h0000_1000`: window base; bits [4:0] must be zero.
- `CLKS_PER_BIT`, `16`: UART bit period in clock cycles; must be ≥ 2.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `memory__address` input 32 (`addr_t`): byte address from the core.
- `memory__write_data` input 32 (`data_t`): store data.
- `memory__write_enable` input 4: per-byte write strobe; bit n covers byte n.
- `memory__read_data` output 32 (`data_t`): load data; combinational from address.
- `hit` output 1: combinational; 1 when `memory__address[31:5] == BASE[31:5]`.
- `gpio_in` input 8: asynchronous pins (`ui_in`).
- `gpio_out` output 8: registered output (`uo_out`).
- `uart_tx` output 1: serial output; idles high.

## Operation
- Register offsets are `address[4:2]`; `address[1:0]` is ignored.
  - 0x00 GPIO_OUT: RW, bits [7:0]; written when byte 0 is strobed.
  - 0x04 GPIO_IN: RO; returns the two-flop-synchronised `gpio_in` in bits [7:0].
  - 0x08 TIMER: RW, 32 bits; increments by 1 every cycle and wraps 0xFFFF_FFFF→0. Writes are byte-granular. Strobed bytes take the write data and unstrobed bytes keep their pre-write value. No increment happens in a write cycle.
  - 0x0C UART_DATA: on a write with byte 0 strobed while not busy, latch `write_data[7:0]` and start a frame. Writes while busy are dropped. A read returns the last latched byte.
  - 0x10 UART_STATUS: RO; bit 0 = busy.
  - 0x14–0x1C: read 0; writes ignored.
- Read data:
  - Unused upper bits of a register read as 0.
  - When `hit`=0, `memory__read_data` = 0.
  - Writes to read-only offsets and writes with `hit`=0 have no effect.
- UART state machine: IDLE → START → DATA → STOP → IDLE.
  - IDLE: tx=1, busy=0.
  - START: tx=0 for `CLKS_PER_BIT` cycles.
  - DATA: 8 bits sent LSB first, each for `CLKS_PER_BIT` cycles.
  - STOP: tx=1 for `CLKS_PER_BIT` cycles, then IDLE.
  - Frame format: 8N1. The bit counter is 3 bits; the cycle counter is sized by `$clog2(CLKS_PER_BIT)`.

## Timing
- Reset values (applied on any clock edge with reset=1): `gpio_out`=0, TIMER=0, synchroniser=0, UART data=0, state=IDLE, `uart_tx`=1, busy=0.
- Reset mid-frame aborts the frame. `uart_tx` is 1 in the cycle after the reset edge.
- Write latency:
  - A store sampled at edge k is visible on `gpio_out` and in register reads from cycle k+1.
  - TIMER reads the written value in cycle k+1 and increments from edge k+1 on.
- GPIO_IN latency: a `gpio_in` change stable before edge k is readable from cycle k+2.
- UART:
  - For a start write at edge k, `uart_tx` falls in cycle k+1 and busy=1 from cycle k+1.
  - The frame occupies cycles k+1 … k+10·`CLKS_PER_BIT`.
  - busy=0 and IDLE from cycle k+10·`CLKS_PER_BIT`+1.
  - A new write is accepted at that edge, not earlier.
- Reads have zero latency: `memory__read_data` follows `memory__address` combinationally and shows register state as of the most recent edge.

## Test plan
- Reset, then read every offset → GPIO_OUT=0, UART_STATUS=0, UART_DATA=0, 0x14–0x1C=0. TIMER counts up from 0. `uart_tx`=1.
- Store 0xDEAD_BEA5 to BASE+0x00 with strobe 4'b0001 → `gpio_out`=0xA5 next cycle. The same store with strobe 4'b1110 → `gpio_out` unchanged. A store to BASE+0x20 → no effect, `hit`=0, read_data=0.
- TIMER: write 0xFFFF_FFFE with all strobes → reads 0xFFFF_FFFE, then 0xFFFF_FFFF, then 0x0000_0000. Then write 0x0000_00AB with strobe 4'b0001 → low byte 0xAB, upper bytes keep their pre-write values.
- Drive `gpio_in`=0x3C → GPIO_IN reads 0x00 for two cycles, then 0x3C.
- With CLKS_PER_BIT=4, write 0x55 to UART_DATA → `uart_tx` sequence 0,1,0,1,0,1,0,1,0,1, each bit held 4 cycles. Busy=1 for exactly 40 cycles. A second write of 0xFF mid-frame is dropped and UART_DATA still reads 0x55.
- Start a frame and assert reset at cycle 10 → `uart_tx`=1 and busy=0 on the following cycle. A write immediately after reset starts a fresh frame.

Source files
------------

// File: rtl/mmio_periph.sv
// Memory-mapped peripheral block: GPIO out/in, free-running cycle timer and an
// 8N1 transmit-only UART, decoded from a 32-byte window on the data memory port.
module mmio_periph #(
    parameter logic [31:0] BASE         = 32'h0000_1000,
    parameter int          CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] memory__address,
    input  logic [31:0] memory__write_data,
    input  logic [3:0]  memory__write_enable,
    output logic [31:0] memory__read_data,
    output logic        hit,
    input  logic [7:0]  gpio_in,
    output logic [7:0]  gpio_out,
    output logic        uart_tx
);

    localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    uart_state_t   state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [2:0]    bit_idx, bit_next;
    logic [7:0]    uart_data;
    logic          busy;

    logic [31:0]   timer, timer_next;
    logic [7:0]    sync_p0, sync_p1;

    logic [2:0]    offset;
    logic          wr_gpio, wr_timer, wr_uart;
    logic          unused_addr_lsb;

    // Byte lane within a word is irrelevant: every register is word-addressed.
    assign unused_addr_lsb = ^memory__address[1:0];

    assign hit      = (memory__address[31:5] == BASE[31:5]);
    assign offset   = memory__address[4:2];
    assign wr_gpio  = hit && (offset == 3'd0) && memory__write_enable[0];
    assign wr_timer = hit && (offset == 3'd2) && (memory__write_enable != 4'b0000);
    assign wr_uart  = hit && (offset == 3'd3) && memory__write_enable[0];
    assign busy     = (state != IDLE);

    always_comb begin
        timer_next = timer + 32'd1;
        if (wr_timer) begin
            for (int i = 0; i < 4; i++) begin
                timer_next[8*i +: 8] = memory__write_enable[i] ? memory__write_data[8*i +: 8]
                                                                : timer[8*i +: 8];
            end
        end
    end

    // Registers and two-flop input synchroniser (stage p0 -> p1)
    always_ff @(posedge clk) begin
        if (reset) begin
            gpio_out  <= 8'h00;
            timer     <= 32'h0;
            sync_p0   <= 8'h00;
            sync_p1   <= 8'h00;
            uart_data <= 8'h00;
        end else begin
            sync_p0 <= gpio_in;
            sync_p1 <= sync_p0;
            timer   <= timer_next;
            if (wr_gpio) begin
                gpio_out <= memory__write_data[7:0];
            end
            if (wr_uart && !busy) begin
                uart_data <= memory__write_data[7:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= 3'd0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        bit_next   = bit_idx;
        uart_tx    = 1'b1;
        case (state)
            IDLE: begin
                if (wr_uart) begin
                    state_next = START;
                    cnt_next   = '0;
                end
            end
            START: begin
                uart_tx = 1'b0;
                if (cnt == CNT_LAST) begin
                    state_next = DATA;
                    cnt_next   = '0;
                    bit_next   = 3'd0;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            DATA: begin
                uart_tx = uart_data[bit_idx];
                if (cnt == CNT_LAST) begin
                    cnt_next = '0;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_next = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            STOP: begin
                if (cnt == CNT_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        memory__read_data = 32'h0;
        if (hit) begin
            case (offset)
                3'd0:    memory__read_data = {24'h0, gpio_out};
                3'd1:    memory__read_data = {24'h0, sync_p1};
                3'd2:    memory__read_data = timer;
                3'd3:    memory__read_data = {24'h0, uart_data};
                3'd4:    memory__read_data = {31'h0, busy};
                default: memory__read_data = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_periph.sv
// Bench for mmio_periph: directed vector table, hand-written timer/GPIO/UART
// sequences, then randomized traffic compared against a frame-level model.
module tb_mmio_periph;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int          CPB  = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] address = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [3:0]  we = 4'h0;
    logic [7:0]  gpio_in = 8'h00;
    logic [31:0] read_data;
    logic        hit;
    logic [7:0]  gpio_out;
    logic        uart_tx;

    int n_cmp = 0;
    int n_fail = 0;

    mmio_periph #(.BASE(BASE), .CLKS_PER_BIT(CPB)) dut (
        .clk                  (clk),
        .reset                (reset),
        .memory__address      (address),
        .memory__write_data   (wdata),
        .memory__write_enable (we),
        .memory__read_data    (read_data),
        .hit                  (hit),
        .gpio_in              (gpio_in),
        .gpio_out             (gpio_out),
        .uart_tx              (uart_tx)
    );

    always #5 clk = ~clk;

    // Reference model: register values plus frame position counted in cycles.
    logic [7:0]  m_gpio = 8'h00, m_s0 = 8'h00, m_s1 = 8'h00, m_udata = 8'h00;
    logic [31:0] m_timer = 32'h0;
    logic        m_active = 1'b0;
    int          m_elapsed = 0;

    function automatic logic m_hit(input logic [31:0] a);
        return a[31:5] == BASE[31:5];
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (!m_hit(a)) return 32'h0;
        case (a[4:2])
            3'd0:    return {24'h0, m_gpio};
            3'd1:    return {24'h0, m_s1};
            3'd2:    return m_timer;
            3'd3:    return {24'h0, m_udata};
            3'd4:    return {31'h0, m_active};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic m_tx();
        logic [9:0] frame;
        if (!m_active) return 1'b1;
        frame = {1'b1, m_udata, 1'b0};
        return frame[m_elapsed / CPB];
    endfunction

    task automatic model_step();
        logic win;
        logic start;
        win = m_hit(address);
        if (reset) begin
            m_gpio = 8'h00; m_s0 = 8'h00; m_s1 = 8'h00; m_udata = 8'h00;
            m_timer = 32'h0; m_active = 1'b0; m_elapsed = 0;
        end else begin
            start = win && (address[4:2] == 3'd3) && we[0] && !m_active;
            if (win && address[4:2] == 3'd0 && we[0]) m_gpio = wdata[7:0];
            if (win && address[4:2] == 3'd2 && we != 4'h0) begin
                for (int i = 0; i < 4; i++)
                    if (we[i]) m_timer[8*i +: 8] = wdata[8*i +: 8];
            end else begin
                m_timer = m_timer + 32'd1;
            end
            m_s1 = m_s0;
            m_s0 = gpio_in;
            if (start) begin
                m_udata = wdata[7:0];
                m_active = 1'b1;
                m_elapsed = 0;
            end else if (m_active) begin
                m_elapsed++;
                if (m_elapsed == 10 * CPB) m_active = 1'b0;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic set_bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        address = a; wdata = d; we = w;
    endtask

    task automatic idle_bus();
        set_bus(32'h0, 32'h0, 4'h0);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_rd;
        logic        exp_hit;
        logic [7:0]  exp_gpio;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [9:0] frame;

        vecs.push_back('{BASE + 32'h00, 32'h0,         4'b0000, 32'h00, 1'b1, 8'h00});
        vecs.push_back('{BASE + 32'h04, 32'h0,         4'b0000, 32'h00, 1'b1, 8'h00});
        vecs.push_back('{BASE + 32'h0C, 32'h0,         4'b0000, 32'h00, 1'b1, 8'h00});
        vecs.push_back('{BASE + 32'h10, 32'h0,         4'b0000, 32'h00, 1'b1, 8'h00});
        vecs.push_back('{BASE + 32'h14, 32'h0,         4'b0000, 32'h00, 1'b1, 8'h00});
        vecs.push_back('{BASE + 32'h18, 32'h0,         4'b0000, 32'h00, 1'b1, 8'h00});
        vecs.push_back('{BASE + 32'h1F, 32'h0,         4'b0000, 32'h00, 1'b1, 8'h00});
        vecs.push_back('{BASE + 32'h00, 32'hDEAD_BEA5, 4'b0001, 32'h00, 1'b1, 8'h00});
        vecs.push_back('{BASE + 32'h02, 32'h0,         4'b0000, 32'hA5, 1'b1, 8'hA5});
        vecs.push_back('{BASE + 32'h00, 32'hDEAD_BEA5, 4'b1110, 32'hA5, 1'b1, 8'hA5});
        vecs.push_back('{BASE + 32'h00, 32'h0,         4'b0000, 32'hA5, 1'b1, 8'hA5});
        vecs.push_back('{BASE + 32'h20, 32'h0000_0011, 4'b1111, 32'h00, 1'b0, 8'hA5});
        vecs.push_back('{BASE + 32'h00, 32'h0,         4'b0000, 32'hA5, 1'b1, 8'hA5});
        vecs.push_back('{BASE + 32'h14, 32'hFFFF_FFFF, 4'b1111, 32'h00, 1'b1, 8'hA5});
        vecs.push_back('{BASE + 32'h14, 32'h0,         4'b0000, 32'h00, 1'b1, 8'hA5});
        vecs.push_back('{BASE + 32'h10, 32'hFFFF_FFFF, 4'b1111, 32'h00, 1'b1, 8'hA5});
        vecs.push_back('{BASE + 32'h10, 32'h0,         4'b0000, 32'h00, 1'b1, 8'hA5});

        // Reset, then timer counts up from zero and the line idles high
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        set_bus(BASE + 32'h08, 32'h0, 4'h0);
        #1;
        check("reset_tx", {31'h0, uart_tx}, 32'h1);
        check("reset_gpio_out", {24'h0, gpio_out}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            check("timer_from_reset", read_data, i);
            tick();
        end

        for (int i = 0; i < vecs.size(); i++) begin
            set_bus(vecs[i].addr, vecs[i].data, vecs[i].strb);
            #1;
            check($sformatf("vec%0d_rd", i), read_data, vecs[i].exp_rd);
            check($sformatf("vec%0d_hit", i), {31'h0, hit}, {31'h0, vecs[i].exp_hit});
            check($sformatf("vec%0d_gpio", i), {24'h0, gpio_out}, {24'h0, vecs[i].exp_gpio});
            tick();
        end

        // Timer wrap and byte-granular write
        set_bus(BASE + 32'h08, 32'hFFFF_FFFE, 4'b1111);
        tick();
        idle_bus();
        address = BASE + 32'h08;
        #1; check("timer_wr", read_data, 32'hFFFF_FFFE); tick();
        check("timer_max", read_data, 32'hFFFF_FFFF); tick();
        check("timer_wrap", read_data, 32'h0000_0000);
        set_bus(BASE + 32'h08, 32'h1234_5600, 4'b1111);
        tick();
        set_bus(BASE + 32'h08, 32'h0000_00AB, 4'b0001);
        tick();
        idle_bus();
        address = BASE + 32'h08;
        #1; check("timer_byte_wr", read_data, 32'h1234_56AB); tick();
        check("timer_after_byte_wr", read_data, 32'h1234_56AC);

        // GPIO input synchroniser latency
        address = BASE + 32'h04;
        gpio_in = 8'h3C;
        #1; check("gpio_in_c0", read_data, 32'h00); tick();
        check("gpio_in_c1", read_data, 32'h00); tick();
        check("gpio_in_c2", read_data, 32'h3C);

        // UART frame of 0x55 with a dropped mid-frame write
        set_bus(BASE + 32'h0C, 32'h0000_0055, 4'b0001);
        tick();
        frame = {1'b1, 8'h55, 1'b0};
        for (int c = 0; c < 10 * CPB; c++) begin
            if (c == 12) set_bus(BASE + 32'h0C, 32'h0000_00FF, 4'b0001);
            else         set_bus(BASE + 32'h10, 32'h0, 4'h0);
            #1;
            check($sformatf("uart_tx_c%0d", c), {31'h0, uart_tx}, {31'h0, frame[c / CPB]});
            if (c != 12) check($sformatf("uart_busy_c%0d", c), read_data, 32'h1);
            tick();
        end
        address = BASE + 32'h10;
        #1;
        check("uart_idle_busy", read_data, 32'h0);
        check("uart_idle_tx", {31'h0, uart_tx}, 32'h1);
        address = BASE + 32'h0C;
        #1;
        check("uart_data_kept", read_data, 32'h55);

        // Reset during a frame, then a fresh frame straight after
        set_bus(BASE + 32'h0C, 32'h0000_00C3, 4'b0001);
        tick();
        idle_bus();
        for (int c = 0; c < 9; c++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        address = BASE + 32'h10;
        #1;
        check("abort_tx", {31'h0, uart_tx}, 32'h1);
        check("abort_busy", read_data, 32'h0);
        set_bus(BASE + 32'h0C, 32'h0000_003C, 4'b0001);
        tick();
        address = BASE + 32'h10; we = 4'h0;
        #1;
        check("restart_tx", {31'h0, uart_tx}, 32'h0);
        check("restart_busy", read_data, 32'h1);
        address = BASE + 32'h0C;
        #1;
        check("restart_data", read_data, 32'h3C);

        // Randomized traffic against the model
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 7) != 0) address = BASE + 32'($urandom_range(0, 31));
            else if ($urandom_range(0, 1) == 0) address = BASE + 32'h20 + 32'($urandom_range(0, 31));
            else address = $urandom;
            wdata = $urandom;
            we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) gpio_in = 8'($urandom);
            #1;
            check("rnd_rd", read_data, m_read(address));
            check("rnd_hit", {31'h0, hit}, {31'h0, m_hit(address)});
            check("rnd_gpio_out", {24'h0, gpio_out}, {24'h0, m_gpio});
            check("rnd_tx", {31'h0, uart_tx}, {31'h0, m_tx()});
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
